// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Parametrised register file with a per-register busy (scoreboard) bit.
//   Decode reads operands and marks destinations busy. Writeback writes
//   data and clears busy. Issue logic checks read_busy_o for RAW hazards.
//
//   Optional feature (macro REGFILE_BYPASS_EN): same-cycle forwarding of
//   the writeback data and busy-clear to matching read ports. When the
//   macro is undefined, reads reflect stored state only.
//
// Ports:
//   clk_i            clock, rising edge
//   reset_ni         asynchronous active-low reset
//   read_addr_i      NREAD packed read addresses, port k at [k*AW +: AW]
//   read_data_o      NREAD packed read data, port k at [k*DATA_W +: DATA_W]
//   read_busy_o      busy flag of the addressed register, per port
//   write_i          writeback strobe
//   write_addr_i     writeback address
//   write_data_i     writeback data
//   set_busy_i       issue strobe, marks set_busy_addr_i pending
//   set_busy_addr_i  destination register being issued
//   flush_i          synchronous clear of all busy bits
//   any_busy_o       OR of stored busy bits
module regfile_scoreboard #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic [NREAD*AW-1:0]     read_addr_i,
  output logic [NREAD*DATA_W-1:0] read_data_o,
  output logic [NREAD-1:0]        read_busy_o,
  input  logic                    write_i,
  input  logic [AW-1:0]           write_addr_i,
  input  logic [DATA_W-1:0]       write_data_i,
  input  logic                    set_busy_i,
  input  logic [AW-1:0]           set_busy_addr_i,
  input  logic                    flush_i,
  output logic                    any_busy_o
);

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;
  logic              wr_en;
  logic              set_en;

  // Register 0 is read-only (and never busy) when ZERO_REG is set.
  function automatic logic writable(input logic [AW-1:0] a);
    return (ZERO_REG == 0) || (a != '0);
  endfunction

  assign wr_en  = write_i && writable(write_addr_i);
  assign set_en = set_busy_i && writable(set_busy_addr_i);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[write_addr_i] <= write_data_i;
    end
  end

  // Order of assignments encodes priority: write clear < set_busy < flush.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[write_addr_i] = 1'b0;
    end
    if (set_en) begin
      busy_d[set_busy_addr_i] = 1'b1;
    end
    if (flush_i) begin
      busy_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Outputs are forced to zero while reset is held so that a bypassed
  // write cannot leak through during reset.
  always_comb begin
    read_data_o = '0;
    read_busy_o = '0;
    if (reset_ni) begin
      for (int unsigned k = 0; k < NREAD; k++) begin
        read_data_o[k*DATA_W +: DATA_W] = mem_q[read_addr_i[k*AW +: AW]];
        read_busy_o[k]                  = busy_q[read_addr_i[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (read_addr_i[k*AW +: AW] == write_addr_i)) begin
          read_data_o[k*DATA_W +: DATA_W] = write_data_i;
          // A same-cycle issue to this register keeps it pending; flush is
          // deliberately not forwarded.
          read_busy_o[k] = set_busy_i && (set_busy_addr_i == write_addr_i);
        end
`endif
      end
    end
  end

  assign any_busy_o = |busy_q;

endmodule
